// File: rtl/bus_transfer_arbiter.sv
// bus_transfer_arbiter: shares a 16-bit tristate DATA bus between NREQ requesters.
// Each granted request is one register-to-register move.
// Sequence per move is DRIVE (source drives the bus) -> LATCH (destination loads) -> TURN.
// TURN keeps every strobe low and pulses done.
// Every output is registered; the output flops load the decode of the next state.
// Optional build macro: BUS_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin, and removes the round-robin pointer.

module bus_transfer_arbiter #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned SEL_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SEL_W-1:0]   req_src,
    input  logic [NREQ*SEL_W-1:0]   req_dst,
    input  logic [NREQ-1:0]         req_offs,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    busy,
    output logic [NREG-1:0]         reg_out,
    output logic [NREG-1:0]         reg_in,
    output logic [NREG-1:0]         reg_offset_in
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StLatch, StTurn} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   src_q, src_d;
    logic [SEL_W-1:0]   dst_q, dst_d;
    logic               offs_q, offs_d;
    logic               inv_q, inv_d;
    logic [IDX_W-1:0]   win_q, win_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic [NREQ-1:0]    done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [NREG-1:0]    reg_out_q, reg_out_d;
    logic [NREG-1:0]    reg_in_q, reg_in_d;
    logic [NREG-1:0]    reg_offset_in_q, reg_offset_in_d;

    logic [NREQ-1:0]    req_masked;
    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [SEL_W-1:0]   sel_src, sel_dst;
    logic               sel_valid;

    // Arbitration: mask the requester whose done is pulsing, then pick the winner.
    always_comb begin
        req_masked = req;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (state_q == StTurn && IDX_W'(i) == win_q) begin
                req_masked[i] = 1'b0;
            end
        end
        found   = 1'b0;
        win_idx = '0;
`ifdef BUS_ARB_FIXED_PRIO_EN
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_masked[k]) begin
                found   = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
`else
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned cand;
            cand = (32'(rr_ptr_q) + k) % NREQ;
            if (!found && req_masked[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
`endif
        sel_src   = req_src[win_idx*SEL_W +: SEL_W];
        sel_dst   = req_dst[win_idx*SEL_W +: SEL_W];
        sel_valid = (32'(sel_src) < NREG) && (32'(sel_dst) < NREG) && (sel_src != sel_dst);
    end

    // Next-state, request capture, and decode of the registered outputs from the next state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        offs_d  = offs_q;
        inv_d   = inv_q;
        win_d   = win_q;
`ifndef BUS_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle, StTurn: begin
                if (found) begin
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    offs_d  = req_offs[win_idx];
                    inv_d   = !sel_valid;
                    win_d   = win_idx;
`ifndef BUS_ARB_FIXED_PRIO_EN
                    rr_ptr_d = win_idx;
`endif
                    // Rejected requests skip the strobes and go straight to done/err.
                    state_d = sel_valid ? StDrive : StTurn;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrive: state_d = StLatch;
            StLatch: state_d = StTurn;
            default: state_d = StIdle;
        endcase

        reg_out_d       = '0;
        reg_in_d        = '0;
        reg_offset_in_d = '0;
        done_d          = '0;
        err_d           = 1'b0;
        busy_d          = (state_d != StIdle);
        if (state_d == StDrive || state_d == StLatch) begin
            reg_out_d = NREG'(1) << src_d;
        end
        if (state_d == StLatch) begin
            if (offs_d) begin
                reg_offset_in_d = NREG'(1) << dst_d;
            end else begin
                reg_in_d = NREG'(1) << dst_d;
            end
        end
        if (state_d == StTurn) begin
            done_d = NREQ'(1) << win_d;
            err_d  = inv_d;
        end
    end

    // State, captured request and output registers; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            src_q           <= '0;
            dst_q           <= '0;
            offs_q          <= 1'b0;
            inv_q           <= 1'b0;
            win_q           <= '0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            rr_ptr_q        <= IDX_W'(NREQ - 1);
`endif
            done_q          <= '0;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
            reg_out_q       <= '0;
            reg_in_q        <= '0;
            reg_offset_in_q <= '0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            dst_q           <= dst_d;
            offs_q          <= offs_d;
            inv_q           <= inv_d;
            win_q           <= win_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
            rr_ptr_q        <= rr_ptr_d;
`endif
            done_q          <= done_d;
            err_q           <= err_d;
            busy_q          <= busy_d;
            reg_out_q       <= reg_out_d;
            reg_in_q        <= reg_in_d;
            reg_offset_in_q <= reg_offset_in_d;
        end
    end

    assign done          = done_q;
    assign err           = err_q;
    assign busy          = busy_q;
    assign reg_out       = reg_out_q;
    assign reg_in        = reg_in_q;
    assign reg_offset_in = reg_offset_in_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: table-driven single moves, contention, reset-in-LATCH,
// and randomized stress against a register-file and arbitration reference model.

module tb_bus_transfer_arbiter;

    localparam int NREG  = 8;
    localparam int NREQ  = 4;
    localparam int SEL_W = 3;
    localparam int NCYC  = 10000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*SEL_W-1:0] req_src, req_dst;
    logic [NREQ-1:0]       req_offs;
    logic [NREQ-1:0]       done;
    logic                  err, busy;
    logic [NREG-1:0]       reg_out, reg_in, reg_offset_in;

    always #5 clk = ~clk;

    bus_transfer_arbiter #(.NREG(NREG), .NREQ(NREQ), .SEL_W(SEL_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_offs      (req_offs),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .reg_offset_in (reg_offset_in)
    );

    // Bus registers driven by the strobes; preload port for setting up source values.
    logic [15:0] regs [NREG];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = '0;
    logic [15:0] pl_val = '0;
    logic [15:0] bus;

    // Wired-OR bus; multiple drivers are caught by the one-hot checks.
    always_comb begin
        bus = '0;
        for (int i = 0; i < NREG; i++) if (reg_out[i]) bus = bus | regs[i];
    end

    // Register file: reset clears, preload or strobed loads otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (pl_en) regs[pl_idx] <= pl_val;
            for (int i = 0; i < NREG; i++) begin
                if (reg_in[i]) regs[i] <= bus;
                else if (reg_offset_in[i]) regs[i] <= {7'b0, bus[8:0]};
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] outs();
        return {reg_out, reg_in, reg_offset_in, done, err, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        tick();
        pl_en  = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [2:0] s, input logic [2:0] d, input logic o);
        req_src[i*SEL_W +: SEL_W] = s;
        req_dst[i*SEL_W +: SEL_W] = d;
        req_offs[i]               = o;
        req[i]                    = 1'b1;
    endtask

    typedef struct {
        int         idx;
        logic [2:0] src;
        logic [2:0] dst;
        logic       offs;
        logic [15:0] pre;
        logic [7:0] e_out;
        logic [7:0] e_in;
        logic [7:0] e_off;
        logic [3:0] e_done;
        logic       e_err;
        logic [15:0] e_val;
    } vec_t;

    vec_t tbl [6];

    // Stress-test state.
    logic [15:0] mdl [NREG];
    logic [2:0]  rs [NREQ];
    logic [2:0]  rd [NREQ];
    logic        ro [NREQ];
    int          gap [NREQ];
    logic [3:0]  req_at [NCYC];
    int          last_w, prev_done_cyc, n_done, w, g, e;
    logic [29:0] exp_o;

    task automatic new_req(input int i);
        rs[i] = 3'($urandom_range(0, 7));
        rd[i] = ($urandom_range(0, 9) == 0) ? rs[i] : 3'($urandom_range(0, 7));
        ro[i] = 1'($urandom_range(0, 1));
        set_req(i, rs[i], rd[i], ro[i]);
    endtask

    initial begin
        tbl[0] = '{0, 3'd2, 3'd5, 1'b0, 16'hBEEF, 8'h04, 8'h20, 8'h00, 4'b0001, 1'b0, 16'hBEEF};
        tbl[1] = '{1, 3'd3, 3'd4, 1'b1, 16'hFFFF, 8'h08, 8'h00, 8'h10, 4'b0010, 1'b0, 16'h01FF};
        tbl[2] = '{2, 3'd6, 3'd6, 1'b0, 16'h1111, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b1, 16'h1111};
        tbl[3] = '{3, 3'd7, 3'd0, 1'b1, 16'h1234, 8'h80, 8'h00, 8'h01, 4'b1000, 1'b0, 16'h0034};
        tbl[4] = '{1, 3'd0, 3'd7, 1'b0, 16'hA5A5, 8'h01, 8'h80, 8'h00, 4'b0010, 1'b0, 16'hA5A5};
        tbl[5] = '{0, 3'd5, 3'd5, 1'b1, 16'h7777, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b1, 16'h7777};

        req = '0; req_src = '0; req_dst = '0; req_offs = '0;
        do_reset();
        check("reset outputs", outs(), '0);

        // Table-driven single transfers.
        for (int v = 0; v < 6; v++) begin
            preload(tbl[v].src, tbl[v].pre);
            set_req(tbl[v].idx, tbl[v].src, tbl[v].dst, tbl[v].offs);
            if (!tbl[v].e_err) begin
                tick();
                check("drive", outs(), {tbl[v].e_out, 8'h00, 8'h00, 4'b0, 1'b0, 1'b1});
                tick();
                check("latch", outs(), {tbl[v].e_out, tbl[v].e_in, tbl[v].e_off, 4'b0, 1'b0, 1'b1});
                tick();
                check("turn", outs(), {8'h00, 8'h00, 8'h00, tbl[v].e_done, 1'b0, 1'b1});
                req = '0;
                tick();
                check("idle after move", outs(), '0);
                check("dst value", regs[tbl[v].dst], tbl[v].e_val);
            end else begin
                tick();
                check("invalid turn", outs(), {8'h00, 8'h00, 8'h00, tbl[v].e_done, 1'b1, 1'b1});
                req = '0;
                tick();
                check("idle after invalid", outs(), '0);
                check("invalid untouched", regs[tbl[v].src], tbl[v].e_val);
            end
        end

        // Contention: all four held, expect round-robin 0,1,2,3,0 every third cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 3'(i + 4), 1'b0);
        for (int s = 1; s <= 15; s++) begin
            tick();
            check("contention done", done, (s % 3 == 0) ? (4'b1 << ((s / 3 - 1) % 4)) : 4'b0);
            check("contention busy", busy, 1'b1);
        end
        req = '0;
        tick();
        check("contention drain", outs(), '0);

        // Reset during LATCH of a 1->7 move, then restart from DRIVE.
        do_reset();
        set_req(1, 3'd1, 3'd7, 1'b0);
        tick();
        check("rst drive", outs(), {8'h02, 8'h00, 8'h00, 4'b0, 1'b0, 1'b1});
        tick();
        check("rst latch", outs(), {8'h02, 8'h80, 8'h00, 4'b0, 1'b0, 1'b1});
        reset = 1'b1;
        tick();
        check("rst in latch", outs(), '0);
        reset = 1'b0;
        tick();
        check("restart drive", outs(), {8'h02, 8'h00, 8'h00, 4'b0, 1'b0, 1'b1});
        tick();
        check("restart latch", outs(), {8'h02, 8'h80, 8'h00, 4'b0, 1'b0, 1'b1});
        tick();
        check("restart turn", outs(), {8'h00, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b1});
        req = '0;
        tick();
        check("restart idle", outs(), '0);

        // Random stress against the reference model.
        do_reset();
        for (int i = 0; i < NREG; i++) begin
            mdl[i] = 16'($urandom);
            preload(3'(i), mdl[i]);
        end
        last_w = NREQ - 1;
        prev_done_cyc = -10;
        n_done = 0;
        for (int i = 0; i < NREQ; i++) gap[i] = $urandom_range(0, 2);
        for (int t = 0; t < NCYC; t++) begin
            tick();
            req_at[t] = req;
            check("one driver", 64'($countones(reg_out) <= 1), 1);
            check("one loader", 64'($countones(reg_in | reg_offset_in) <= 1), 1);
            check("in and offset", 64'(|(reg_in & reg_offset_in)), 0);
            check("one grant", 64'($countones(done) <= 1), 1);
            if (|done) begin
                n_done++;
                w = 0;
                for (int i = 0; i < NREQ; i++) if (done[i]) w = i;
                g = err ? t : t - 2;
                if (g < 0) g = 0;
                e = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (last_w + k) % NREQ;
                    if (e < 0 && req_at[g][c] && !(prev_done_cyc == g - 1 && c == last_w)) e = c;
                end
                check("rr winner", 64'(w), 64'(e));
                check("err flag", err, (rs[w] == rd[w]));
                if (rs[w] != rd[w]) begin
                    mdl[rd[w]] = ro[w] ? {7'b0, mdl[rs[w]][8:0]} : mdl[rs[w]];
                    check("scoreboard dst", regs[rd[w]], mdl[rd[w]]);
                end
                last_w = w;
                prev_done_cyc = t;
                req[w] = 1'b0;
                gap[w] = $urandom_range(0, 3);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if (gap[i] == 0) new_req(i);
                    else gap[i]--;
                end
            end
        end
        req = '0;
        for (int k = 0; k < 6; k++) tick();
        check("stress progress", 64'(n_done > 100), 1);
        check("stress idle", outs(), '0);
        for (int i = 0; i < NREG; i++) check("final reg", regs[i], mdl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
